// File: rtl/kmeans_pkg.sv
// Shared definitions for the two-centroid, four-dimension k-means update block.
package kmeans_pkg;

  localparam int unsigned NumDims      = 4;
  localparam int unsigned NumCentroids = 2;
  localparam int unsigned NumElems     = NumDims * NumCentroids;
  localparam int unsigned DimIdxWidth  = $clog2(NumDims);
  localparam int unsigned ElemIdxWidth = $clog2(NumElems);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/kmeans_divider_seq.sv
// Restoring unsigned divider: one load cycle, then one quotient bit per cycle.
// done and quotient are valid during the final iteration cycle.
module kmeans_divider_seq #(
  parameter int unsigned dividend_width = 32,
  parameter int unsigned divisor_width  = 16,
  parameter int unsigned quotient_width = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      done,
  output logic [quotient_width-1:0] quotient
);

  localparam int unsigned IterWidth = $clog2(dividend_width + 1);

  logic [dividend_width-1:0] quo_q, quo_d;
  logic [divisor_width-1:0]  rem_q, rem_d, div_q;
  logic [divisor_width:0]    rem_shift;
  logic [IterWidth-1:0]      iter_q;
  logic                      active_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[dividend_width-1]};
    quo_d     = {quo_q[dividend_width-2:0], 1'b0};
    rem_d     = rem_shift[divisor_width-1:0];
    if (rem_shift >= {1'b0, div_q}) begin
      // Remainder stays below the divisor, so the low bits of the difference are exact.
      rem_d    = rem_shift[divisor_width-1:0] - div_q;
      quo_d[0] = 1'b1;
    end
    done     = active_q && (iter_q == IterWidth'(1));
    quotient = quo_d[quotient_width-1:0];
  end

  // Load on start, then iterate dividend_width times.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      iter_q   <= '0;
      active_q <= 1'b0;
    end else if (start && !active_q) begin
      quo_q    <= dividend;
      rem_q    <= '0;
      div_q    <= divisor;
      iter_q   <= IterWidth'(dividend_width);
      active_q <= 1'b1;
    end else if (active_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      iter_q <= iter_q - 1'b1;
      if (iter_q == IterWidth'(1)) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/kmeans_centroid_update_k2_d4.sv
// Accumulates per-centroid sums and counts over an epoch, then divides them
// sequentially into new centroids with a single shared divider.
module kmeans_centroid_update_k2_d4
  import kmeans_pkg::*;
#(
  parameter int unsigned input_data_width = 16,
  parameter int unsigned count_width      = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [NumDims*input_data_width-1:0]  input_data,
  input  logic                                selected_centroid,
  input  logic [NumElems*input_data_width-1:0] centroid_in,
  output logic [NumElems*input_data_width-1:0] centroid_out,
  output logic                                update_valid,
  output logic                                busy,
  output logic                                overflow
);

  localparam int unsigned SumWidth = input_data_width + count_width;
  localparam logic [ElemIdxWidth-1:0] LastElem = ElemIdxWidth'(NumElems - 1);

  logic [NumDims-1:0][input_data_width-1:0]                din;
  logic [NumElems-1:0][input_data_width-1:0]               cin;
  logic [NumElems-1:0][input_data_width-1:0]               res_q, out_q;
  logic [NumCentroids-1:0][NumDims-1:0][SumWidth-1:0]      sum_q;
  logic [NumCentroids-1:0][count_width-1:0]                cnt_q;
  logic [count_width-1:0]                                  cur_cnt;
  logic [ElemIdxWidth-1:0]                                 idx_q;
  logic                                                    cur_k;
  logic [DimIdxWidth-1:0]                                  cur_d;
  logic                                                    pending_q, overflow_q, accept;
  logic                                                    div_start, div_done, elem_done;
  logic [input_data_width-1:0]                             div_quotient, elem_val;
  state_e                                                  state_q, state_d;

  assign din          = input_data;
  assign cin          = centroid_in;
  assign centroid_out = out_q;
  assign overflow     = overflow_q;
  assign in_ready     = (state_q == StAcc);
  assign busy         = (state_q != StIdle);
  assign update_valid = (state_q == StDone);
  assign accept       = in_ready && in_valid;
  assign cur_k        = idx_q[ElemIdxWidth-1];
  assign cur_d        = idx_q[DimIdxWidth-1:0];
  assign cur_cnt      = cnt_q[cur_k];

  kmeans_divider_seq #(
    .dividend_width (SumWidth),
    .divisor_width  (count_width),
    .quotient_width (input_data_width)
  ) u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (sum_q[cur_k][cur_d]),
    .divisor  (cur_cnt),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // Next state plus per-element divide sequencing.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    elem_done = 1'b0;
    elem_val  = cin[idx_q];
    unique case (state_q)
      StIdle: if (start) state_d = StAcc;
      StAcc:  if (in_valid && in_last) state_d = StDiv;
      StDiv: begin
        // Empty centroids keep their previous position and skip the divider.
        if (cur_cnt == '0) begin
          elem_done = 1'b1;
        end else if (pending_q) begin
          elem_done = div_done;
          elem_val  = div_quotient;
        end else begin
          div_start = 1'b1;
        end
        if (elem_done && (idx_q == LastElem)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Accumulation, quotient collection and the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      out_q      <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        sum_q      <= '0;
        cnt_q      <= '0;
        idx_q      <= '0;
        pending_q  <= 1'b0;
        overflow_q <= 1'b0;
      end
      if (accept) begin
        // A saturated counter drops the whole beat so sums cannot wrap.
        if (cnt_q[selected_centroid] == '1) begin
          overflow_q <= 1'b1;
        end else begin
          cnt_q[selected_centroid] <= cnt_q[selected_centroid] + 1'b1;
          for (int d = 0; d < NumDims; d++) begin
            sum_q[selected_centroid][d] <= sum_q[selected_centroid][d] + SumWidth'(din[d]);
          end
        end
      end
      if (div_start) pending_q <= 1'b1;
      if (elem_done) begin
        pending_q    <= 1'b0;
        res_q[idx_q] <= elem_val;
        idx_q        <= idx_q + 1'b1;
        // The visible result changes only once, as the last quotient lands.
        if (idx_q == LastElem) begin
          out_q           <= res_q;
          out_q[LastElem] <= elem_val;
        end
      end
    end
  end

endmodule
